// File: rtl/vga_keypad_renderer.sv
// Keypad renderer: ROWS x COLS bordered tiles with seven-segment glyphs, a
// frame-synchronised cursor highlight and a timed select flash, 2-clk pixel pipeline.
module vga_keypad_renderer #(
    parameter int COLS         = 4,
    parameter int ROWS         = 4,
    parameter int ORIGIN_X     = 40,
    parameter int ORIGIN_Y     = 60,
    parameter int TILE_W       = 90,
    parameter int TILE_H       = 100,
    parameter int SEG_T        = 5,
    parameter int RGB_W        = 8,
    parameter int FLASH_FRAMES = 8,
    parameter logic [RGB_W-1:0] FG     = RGB_W'(8'hFF),
    parameter logic [RGB_W-1:0] BORDER = RGB_W'(8'h49),
    parameter logic [RGB_W-1:0] CURSOR = RGB_W'(8'hFC),
    parameter logic [RGB_W-1:0] FLASH  = RGB_W'(8'hE0)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [RGB_W-1:0] bg,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_sel,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic [RGB_W-1:0] rgb_o,
    output logic             key_valid,
    output logic [3:0]       key_code,
    output logic [5:0]       cursor_idx
);

    typedef enum logic {S_IDLE, S_FLASH} state_t;

    function automatic logic [5:0] tile_idx(input logic [2:0] r, input logic [2:0] c);
        return 6'({3'd0, r} * 6'(COLS)) + {3'd0, c};
    endfunction

    function automatic logic in_rng(input logic [31:0] v, input int lo, input int hi);
        return (v >= 32'(lo)) && (v <= 32'(hi));
    endfunction

    // Segment enables packed as {h,g,f,e,d,c,b,a}.
    function automatic logic [7:0] glyph_segs(input logic [3:0] code);
        case (code)
            4'd0:    return 8'b0011_1111;
            4'd1:    return 8'b0000_0110;
            4'd2:    return 8'b0101_1011;
            4'd3:    return 8'b0100_1111;
            4'd4:    return 8'b0110_0110;
            4'd5:    return 8'b0110_1101;
            4'd6:    return 8'b0111_1101;
            4'd7:    return 8'b0000_0111;
            4'd8:    return 8'b0111_1111;
            4'd9:    return 8'b0110_1111;
            4'd10:   return 8'b1100_0000;
            4'd11:   return 8'b0100_0000;
            4'd12:   return 8'b0100_1000;
            4'd13:   return 8'b0011_1001;
            4'd14:   return 8'b0111_1001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    logic [31:0] px, py;
    logic        hx, hy, frame_s;
    logic [2:0]  col_s, row_s;
    logic [6:0]  lx_s, ly_s;

    assign px = {22'd0, pixel_x};
    assign py = {22'd0, pixel_y};

    always_comb begin
        hx    = 1'b0;
        hy    = 1'b0;
        col_s = 3'd0;
        row_s = 3'd0;
        lx_s  = 7'd0;
        ly_s  = 7'd0;
        for (int c = 0; c < COLS; c++) begin
            if (in_rng(px, ORIGIN_X + c * TILE_W, ORIGIN_X + c * TILE_W + 70)) begin
                hx    = 1'b1;
                col_s = 3'(c);
                lx_s  = 7'(px - 32'(ORIGIN_X + c * TILE_W));
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (in_rng(py, ORIGIN_Y + r * TILE_H, ORIGIN_Y + r * TILE_H + 95)) begin
                hy    = 1'b1;
                row_s = 3'(r);
                ly_s  = 7'(py - 32'(ORIGIN_Y + r * TILE_H));
            end
        end
        frame_s = (px <= 32'd10) || (px >= 32'd620) || (py <= 32'd10) || (py >= 32'd470);
    end

    // Stage 1: tile coordinates, local offsets, hit flags, video_on and syncs
    logic [2:0] col_p1, row_p1;
    logic [6:0] lx_p1, ly_p1;
    logic       in_tile_p1, frame_p1;
    logic       vld_p1, hs_p1, vs_p1;

    always_ff @(posedge clk) begin
        col_p1     <= col_s;
        row_p1     <= row_s;
        lx_p1      <= lx_s;
        ly_p1      <= ly_s;
        in_tile_p1 <= hx & hy;
        frame_p1   <= frame_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
        end else begin
            vld_p1 <= video_on;
            hs_p1  <= hsync_i;
            vs_p1  <= vsync_i;
        end
    end

    // Cursor, shadow copy and select FSM
    logic [2:0]  col_q, row_q, col_n, row_n, sh_col, sh_row;
    logic        vs_d, tick;
    state_t      state_q, state_n;
    logic [7:0]  cnt_q, cnt_n;
    logic [5:0]  flash_idx_q, flash_idx_n, cur_idx;

    assign tick       = vs_d & ~vsync_i;
    assign cur_idx    = tile_idx(row_q, col_q);
    assign cursor_idx = cur_idx;

    always_comb begin
        col_n = col_q;
        row_n = row_q;
        if (btn_up)
            row_n = (row_q == 3'd0) ? 3'(ROWS - 1) : row_q - 3'd1;
        else if (btn_down)
            row_n = (row_q == 3'(ROWS - 1)) ? 3'd0 : row_q + 3'd1;
        else if (btn_left)
            col_n = (col_q == 3'd0) ? 3'(COLS - 1) : col_q - 3'd1;
        else if (btn_right)
            col_n = (col_q == 3'(COLS - 1)) ? 3'd0 : col_q + 3'd1;
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        flash_idx_n = flash_idx_q;
        if (btn_sel) begin
            state_n     = S_FLASH;
            cnt_n       = 8'(FLASH_FRAMES);
            flash_idx_n = cur_idx;
        end else if (state_q == S_FLASH && tick) begin
            if (cnt_q <= 8'd1) begin
                cnt_n   = 8'd0;
                state_n = S_IDLE;
            end else begin
                cnt_n = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= 3'd0;
            row_q       <= 3'd0;
            sh_col      <= 3'd0;
            sh_row      <= 3'd0;
            vs_d        <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            flash_idx_q <= 6'd0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
        end else begin
            col_q       <= col_n;
            row_q       <= row_n;
            vs_d        <= vsync_i;
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            flash_idx_q <= flash_idx_n;
            key_valid   <= btn_sel;
            key_code    <= cur_idx[3:0];
            if (tick) begin
                sh_col <= col_q;
                sh_row <= row_q;
            end
        end
    end

    logic [31:0]      lxw, lyw;
    logic [5:0]       idx_p1;
    logic [7:0]       seg_hit, glyph;
    logic             ring_hit, glyph_hit;
    logic [RGB_W-1:0] rgb_n;

    assign lxw    = {25'd0, lx_p1};
    assign lyw    = {25'd0, ly_p1};
    assign idx_p1 = tile_idx(row_p1, col_p1);
    assign glyph  = (idx_p1 < 6'd16) ? glyph_segs(idx_p1[3:0]) : 8'd0;

    always_comb begin
        seg_hit[0] = in_rng(lxw, 20, 50) && in_rng(lyw, 20, 20 + SEG_T);
        seg_hit[1] = in_rng(lxw, 45, 50) && in_rng(lyw, 20, 45);
        seg_hit[2] = in_rng(lxw, 45, 50) && in_rng(lyw, 45, 70);
        seg_hit[3] = in_rng(lxw, 20, 50) && in_rng(lyw, 70, 75);
        seg_hit[4] = in_rng(lxw, 20, 20 + SEG_T) && in_rng(lyw, 45, 70);
        seg_hit[5] = in_rng(lxw, 20, 20 + SEG_T) && in_rng(lyw, 20, 45);
        seg_hit[6] = in_rng(lxw, 20, 50) && in_rng(lyw, 45, 50);
        seg_hit[7] = in_rng(lxw, 33, 37) && in_rng(lyw, 30, 60);
        glyph_hit  = in_tile_p1 && (|(glyph & seg_hit));
        ring_hit   = in_tile_p1 && ((lxw < 32'(SEG_T)) || (lxw > 32'(70 - SEG_T)) ||
                                    (lyw < 32'(SEG_T)) || (lyw > 32'(95 - SEG_T)));
        rgb_n = bg;
        if (!vld_p1)
            rgb_n = '0;
        else if (frame_p1)
            rgb_n = BORDER;
        else if (glyph_hit)
            rgb_n = FG;
        else if (ring_hit) begin
            if (state_q == S_FLASH && idx_p1 == flash_idx_q)
                rgb_n = FLASH;
            else if (idx_p1 == tile_idx(sh_row, sh_col))
                rgb_n = CURSOR;
            else
                rgb_n = BORDER;
        end
    end

    // Stage 2: glyph lookup, priority mux and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_o   <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            rgb_o   <= rgb_n;
            hsync_o <= hs_p1;
            vsync_o <= vs_p1;
        end
    end

endmodule

// File: tb/tb_vga_keypad_renderer.sv
// Directed bench for vga_keypad_renderer: rendering, latency, cursor, select/flash, reset.
module tb_vga_keypad_renderer;

    localparam logic [7:0] FG_C = 8'hFF, BORDER_C = 8'h49, CURSOR_C = 8'hFC, FLASH_C = 8'hE0, BG_C = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pixel_x = 10'd300, pixel_y = 10'd30;
    logic       video_on = 1'b1, hsync_i = 1'b1, vsync_i = 1'b1;
    logic [7:0] bg = BG_C;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic       hsync_o, vsync_o, key_valid;
    logic [7:0] rgb_o;
    logic [3:0] key_code;
    logic [5:0] cursor_idx;
    logic       hs5, vs5, kv5;
    logic [7:0] rgb5;
    logic [3:0] kc5;
    logic [5:0] ci5;

    int cmp = 0;
    int err = 0;

    always #5 clk = ~clk;

    vga_keypad_renderer #(.FG(FG_C), .BORDER(BORDER_C), .CURSOR(CURSOR_C), .FLASH(FLASH_C)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .bg(bg), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .rgb_o(rgb_o), .key_valid(key_valid), .key_code(key_code),
        .cursor_idx(cursor_idx));

    vga_keypad_renderer #(.COLS(5), .ROWS(4), .FG(FG_C), .BORDER(BORDER_C), .CURSOR(CURSOR_C), .FLASH(FLASH_C)) dut5 (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .bg(bg), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel), .hsync_o(hs5),
        .vsync_o(vs5), .rgb_o(rgb5), .key_valid(kv5), .key_code(kc5), .cursor_idx(ci5));

    task automatic probe(input int x, input int y, output logic [7:0] c, output logic [7:0] c5);
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        @(posedge clk);
        @(posedge clk);
        #1;
        c  = rgb_o;
        c5 = rgb5;
    endtask

    task automatic tick();
        @(negedge clk);
        vsync_i = 1'b0;
        @(negedge clk);
        vsync_i = 1'b1;
    endtask

    // b = {up, down, left, right, sel}; returns #1 after the capturing edge
    task automatic press(input logic [4:0] b);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = b;
        @(posedge clk);
        #1;
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp++; if (rgb_o !== 8'h00) begin err++; $display("FAIL reset_rgb got=%h exp=00", rgb_o); end
        cmp++; if ({hsync_o, vsync_o} !== 2'b11) begin err++; $display("FAIL reset_sync got=%b exp=11", {hsync_o, vsync_o}); end
        cmp++; if (key_valid !== 1'b0 || key_code !== 4'd0) begin err++; $display("FAIL reset_key got=%b/%0d exp=0/0", key_valid, key_code); end
        cmp++; if (cursor_idx !== 6'd0) begin err++; $display("FAIL reset_cursor got=%0d exp=0", cursor_idx); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_render();
        int         xs[10] = '{165, 152, 177, 255, 345, 50, 140, 5, 300, 75};
        int         ys[10] = '{185, 190, 190, 295, 295, 60, 60, 200, 30, 307};
        logic [7:0] ex[10] = '{FG_C, FG_C, BG_C, FG_C, BG_C, CURSOR_C, BORDER_C, BORDER_C, BG_C, FG_C};
        logic [7:0] c, c5;
        for (int i = 0; i < 10; i++) begin
            probe(xs[i], ys[i], c, c5);
            cmp++; if (c !== ex[i]) begin err++; $display("FAIL render_%0d (%0d,%0d) got=%h exp=%h", i, xs[i], ys[i], c, ex[i]); end
        end
        probe(75, 107, c, c5);
        cmp++; if (c !== BG_C) begin err++; $display("FAIL render_zero_no_g got=%h exp=%h", c, BG_C); end
    endtask

    task automatic test_latency();
        logic [7:0] c, c5;
        probe(300, 30, c, c5);
        @(negedge clk);
        pixel_x = 10'd165; pixel_y = 10'd185; hsync_i = 1'b0; vsync_i = 1'b0;
        @(posedge clk); #1;
        cmp++; if (rgb_o !== BG_C || hsync_o !== 1'b1 || vsync_o !== 1'b1) begin err++; $display("FAIL latency_1clk got=%h/%b%b exp=%h/11", rgb_o, hsync_o, vsync_o, BG_C); end
        @(posedge clk); #1;
        cmp++; if (rgb_o !== FG_C || hsync_o !== 1'b0 || vsync_o !== 1'b0) begin err++; $display("FAIL latency_2clk got=%h/%b%b exp=%h/00", rgb_o, hsync_o, vsync_o, FG_C); end
        @(negedge clk);
        hsync_i = 1'b1; vsync_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        cmp++; if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin err++; $display("FAIL latency_release got=%b%b exp=11", hsync_o, vsync_o); end
    endtask

    task automatic test_video_off();
        logic [7:0] c, c5;
        video_on = 1'b0;
        probe(165, 185, c, c5);
        cmp++; if (c !== 8'h00) begin err++; $display("FAIL video_off_glyph got=%h exp=00", c); end
        probe(5, 200, c, c5);
        cmp++; if (c !== 8'h00) begin err++; $display("FAIL video_off_frame got=%h exp=00", c); end
        video_on = 1'b1;
    endtask

    task automatic test_wide_build();
        logic [7:0] c, c5;
        probe(160, 382, c, c5);
        cmp++; if (c5 !== BG_C) begin err++; $display("FAIL wide_idx16_glyph got=%h exp=%h", c5, BG_C); end
        cmp++; if (c !== FG_C) begin err++; $display("FAIL narrow_idx13_glyph got=%h exp=%h", c, FG_C); end
        probe(130, 400, c, c5);
        cmp++; if (c5 !== BORDER_C) begin err++; $display("FAIL wide_idx16_ring got=%h exp=%h", c5, BORDER_C); end
        probe(70, 82, c, c5);
        cmp++; if (c5 !== FG_C) begin err++; $display("FAIL wide_idx0_glyph got=%h exp=%h", c5, FG_C); end
    endtask

    task automatic test_cursor();
        logic [7:0] c, c5;
        press(5'b00100);
        cmp++; if (cursor_idx !== 6'd3) begin err++; $display("FAIL cursor_left_wrap got=%0d exp=3", cursor_idx); end
        probe(50, 60, c, c5);
        cmp++; if (c !== CURSOR_C) begin err++; $display("FAIL cursor_shadow_old got=%h exp=%h", c, CURSOR_C); end
        probe(310, 100, c, c5);
        cmp++; if (c !== BORDER_C) begin err++; $display("FAIL cursor_shadow_new_early got=%h exp=%h", c, BORDER_C); end
        tick();
        probe(50, 60, c, c5);
        cmp++; if (c !== BORDER_C) begin err++; $display("FAIL cursor_old_after_tick got=%h exp=%h", c, BORDER_C); end
        probe(310, 100, c, c5);
        cmp++; if (c !== CURSOR_C) begin err++; $display("FAIL cursor_new_after_tick got=%h exp=%h", c, CURSOR_C); end
        press(5'b10000);
        cmp++; if (cursor_idx !== 6'd15) begin err++; $display("FAIL cursor_up_wrap got=%0d exp=15", cursor_idx); end
        press(5'b01000);
        press(5'b00010);
        cmp++; if (cursor_idx !== 6'd0) begin err++; $display("FAIL cursor_down_right_wrap got=%0d exp=0", cursor_idx); end
        press(5'b10010);
        cmp++; if (cursor_idx !== 6'd12) begin err++; $display("FAIL cursor_up_priority got=%0d exp=12", cursor_idx); end
        press(5'b01000);
        press(5'b01000);
        press(5'b01000);
        press(5'b00010);
        cmp++; if (cursor_idx !== 6'd9) begin err++; $display("FAIL cursor_to_1_2 got=%0d exp=9", cursor_idx); end
        tick();
    endtask

    task automatic test_select();
        logic [7:0] c, c5;
        press(5'b00001);
        cmp++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin err++; $display("FAIL select_pulse got=%b/%0d exp=1/9", key_valid, key_code); end
        @(posedge clk); #1;
        cmp++; if (key_valid !== 1'b0) begin err++; $display("FAIL select_width got=%b exp=0", key_valid); end
        probe(130, 300, c, c5);
        cmp++; if (c !== FLASH_C) begin err++; $display("FAIL flash_start got=%h exp=%h", c, FLASH_C); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            probe(130, 300, c, c5);
            cmp++; if (c !== ((k < 8) ? FLASH_C : CURSOR_C)) begin err++; $display("FAIL flash_tick%0d got=%h exp=%h", k, c, (k < 8) ? FLASH_C : CURSOR_C); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c, c5;
        @(negedge clk); btn_sel = 1'b1;
        @(posedge clk); #1;
        cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL b2b_first got=%b exp=1", key_valid); end
        @(posedge clk); #1;
        cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL b2b_second got=%b exp=1", key_valid); end
        btn_sel = 1'b0;
        @(posedge clk); #1;
        cmp++; if (key_valid !== 1'b0) begin err++; $display("FAIL b2b_end got=%b exp=0", key_valid); end
        repeat (5) tick();
        probe(130, 300, c, c5);
        cmp++; if (c !== FLASH_C) begin err++; $display("FAIL restart_before got=%h exp=%h", c, FLASH_C); end
        press(5'b00001);
        repeat (7) tick();
        probe(130, 300, c, c5);
        cmp++; if (c !== FLASH_C) begin err++; $display("FAIL restart_tick7 got=%h exp=%h", c, FLASH_C); end
        tick();
        probe(130, 300, c, c5);
        cmp++; if (c !== CURSOR_C) begin err++; $display("FAIL restart_tick8 got=%h exp=%h", c, CURSOR_C); end
    endtask

    task automatic test_move_select();
        logic [7:0] c, c5;
        press(5'b00011);
        cmp++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin err++; $display("FAIL movesel_code got=%b/%0d exp=1/9", key_valid, key_code); end
        cmp++; if (cursor_idx !== 6'd10) begin err++; $display("FAIL movesel_cursor got=%0d exp=10", cursor_idx); end
        tick();
        probe(130, 300, c, c5);
        cmp++; if (c !== FLASH_C) begin err++; $display("FAIL movesel_flash_tile got=%h exp=%h", c, FLASH_C); end
        probe(220, 300, c, c5);
        cmp++; if (c !== CURSOR_C) begin err++; $display("FAIL movesel_cursor_tile got=%h exp=%h", c, CURSOR_C); end
    endtask

    task automatic test_reset_mid_flash();
        logic [7:0] c, c5;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp++; if (rgb_o !== 8'h00 || hsync_o !== 1'b1) begin err++; $display("FAIL midreset_out got=%h/%b exp=00/1", rgb_o, hsync_o); end
        cmp++; if (cursor_idx !== 6'd0) begin err++; $display("FAIL midreset_cursor got=%0d exp=0", cursor_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        probe(130, 300, c, c5);
        cmp++; if (c !== BORDER_C) begin err++; $display("FAIL midreset_flash_cleared got=%h exp=%h", c, BORDER_C); end
        probe(50, 60, c, c5);
        cmp++; if (c !== CURSOR_C) begin err++; $display("FAIL midreset_cursor_ring got=%h exp=%h", c, CURSOR_C); end
    endtask

    initial begin
        test_reset();
        test_wide_build();
        test_render();
        test_latency();
        test_video_off();
        test_cursor();
        test_select();
        test_back_to_back();
        test_move_select();
        test_reset_mid_flash();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
